// File: rtl/stream_packer_arb.sv
// stream_packer_arb: packet-granular round-robin arbiter that merges N_SRC
// sparse AXI-Stream sources into one tagged stream feeding stream_packer.
module stream_packer_arb #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned N_BYTES = 4,
  parameter int unsigned SRC_W   = $clog2(N_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC*N_BYTES*8-1:0] s_tdata,
  input  logic [N_SRC*N_BYTES-1:0]   s_tkeep,
  input  logic [N_SRC-1:0]           s_tlast,
  input  logic [N_SRC-1:0]           s_tvalid,
  output logic [N_SRC-1:0]           s_tready,
  input  logic [N_SRC-1:0]           src_en,
  output logic [N_BYTES*8-1:0]       m_tdata,
  output logic [N_BYTES-1:0]         m_tkeep,
  output logic                       m_tlast,
  output logic [SRC_W-1:0]           m_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       busy
);

  localparam int unsigned DW = N_BYTES * 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  logic             state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] gnt_q, gnt_d;

  logic [DW-1:0]      m_tdata_q, m_tdata_d;
  logic [N_BYTES-1:0] m_tkeep_q, m_tkeep_d;
  logic               m_tlast_q, m_tlast_d;
  logic [SRC_W-1:0]   m_tuser_q, m_tuser_d;
  logic               m_tvalid_q, m_tvalid_d;

  logic [N_SRC-1:0]   cand_c;
  logic               arb_found_c;
  logic [SRC_W-1:0]   arb_idx_c;
  int unsigned        arb_pos_c;

  logic [DW-1:0]      sel_data_c;
  logic [N_BYTES-1:0] sel_keep_c;
  logic               sel_last_c;
  logic               sel_valid_c;
  logic               acc_c;
  logic               acc_beat_c;
  logic               load_c;

  // Output register can take a new beat when empty or draining this cycle
  assign acc_c = !m_tvalid_q || m_tready;

  // Round-robin search upward from ptr+1 over enabled, valid sources
  always_comb begin
    cand_c      = s_tvalid & src_en;
    arb_found_c = 1'b0;
    arb_idx_c   = '0;
    arb_pos_c   = 0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      arb_pos_c = (32'(ptr_q) + k) % N_SRC;
      if (!arb_found_c && cand_c[SRC_W'(arb_pos_c)]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = SRC_W'(arb_pos_c);
      end
    end
  end

  // Mux the granted source's beat and drive its ready bit only
  always_comb begin
    sel_data_c  = '0;
    sel_keep_c  = '0;
    sel_last_c  = 1'b0;
    sel_valid_c = 1'b0;
    s_tready    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (gnt_q == SRC_W'(i)) begin
        sel_data_c  = s_tdata[i*DW +: DW];
        sel_keep_c  = s_tkeep[i*N_BYTES +: N_BYTES];
        sel_last_c  = s_tlast[i];
        sel_valid_c = s_tvalid[i];
        s_tready[i] = (state_q == ST_LOCK) && acc_c;
      end
    end
  end

  // Empty non-last beats are consumed but never forwarded
  assign acc_beat_c = (state_q == ST_LOCK) && sel_valid_c && acc_c;
  assign load_c     = acc_beat_c && ((|sel_keep_c) || sel_last_c);

  // Grant FSM: arbitrate in IDLE, hold grant until tlast is accepted
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_c) begin
          gnt_d   = arb_idx_c;
          ptr_d   = arb_idx_c;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (acc_beat_c && sel_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next value: load, drain or hold
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    m_tvalid_d = m_tvalid_q;
    if (load_c) begin
      m_tdata_d  = sel_data_c;
      m_tkeep_d  = sel_keep_c;
      m_tlast_d  = sel_last_c;
      m_tuser_d  = gnt_q;
      m_tvalid_d = 1'b1;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= SRC_W'(N_SRC - 1);
      gnt_q      <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;
  assign m_tvalid = m_tvalid_q;
  assign busy     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_stream_packer_arb.sv
// Self-checking bench for stream_packer_arb: queue-based source drivers and a
// packet-level round-robin reference model predicting the output stream.
module tb_stream_packer_arb;

  localparam int N  = 4;
  localparam int NB = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  user;
  } obeat_t;

  logic              clk;
  logic              rst_n;
  logic [N*NB*8-1:0] s_tdata;
  logic [N*NB-1:0]   s_tkeep;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [N-1:0]      src_en;
  logic [31:0]       m_tdata;
  logic [3:0]        m_tkeep;
  logic              m_tlast;
  logic [1:0]        m_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic              busy;

  stream_packer_arb #(.N_SRC(N), .N_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .src_en(src_en),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  beat_t  srcq [N][$];
  beat_t  mq   [N][$];
  obeat_t exp_q[$];
  int     ptr_m;

  int       cyc;
  int       acc_cnt [N];
  logic     bp_mode;
  logic     gap_chk;
  logic     after_last;
  int       last_acc_cyc;
  logic     prev_last_hs;
  logic     prev_stall;
  obeat_t   prev_o;
  logic [3:0] smp_ready;
  logic     smp_busy;
  logic     smp_mvalid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input int s, input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b = '{data: d, keep: k, last: l};
    srcq[s].push_back(b);
    mq[s].push_back(b);
  endtask

  task automatic push_rand_pkt(input int s, input int n, input logic allow_empty);
    for (int j = 0; j < n; j++) begin
      logic [3:0] k;
      k = allow_empty ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 15));
      push_beat(s, $urandom, k, j == n - 1);
    end
  endtask

  // Packet-level reference: pick next pending enabled source after ptr, emit whole packet
  task automatic predict(input logic [3:0] en, input int max_pkts);
    for (int p = 0; p < max_pkts; p++) begin
      int found;
      beat_t b;
      found = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (ptr_m + k) % N;
        if (found < 0 && en[idx] && mq[idx].size() > 0) found = idx;
      end
      if (found < 0) break;
      ptr_m = found;
      do begin
        b = mq[found].pop_front();
        if (b.keep != 4'd0 || b.last)
          exp_q.push_back('{data: b.data, keep: b.keep, last: b.last, user: 2'(found)});
      end while (!b.last);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i]             = 1'b1;
        s_tdata[i*32 +: 32]     = srcq[i][0].data;
        s_tkeep[i*NB +: NB]     = srcq[i][0].keep;
        s_tlast[i]              = srcq[i][0].last;
      end else begin
        s_tvalid[i]             = 1'b0;
        s_tdata[i*32 +: 32]     = '0;
        s_tkeep[i*NB +: NB]     = '0;
        s_tlast[i]              = 1'b0;
      end
    end
  endtask

  // One clock: sample/check at negedge, advance drivers just after posedge
  task automatic step();
    logic [3:0] hs;
    obeat_t o, e;
    @(negedge clk);
    cyc++;
    o = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
    smp_ready  = s_tready;
    smp_busy   = busy;
    smp_mvalid = m_tvalid;
    chk("ready_onehot0", 64'($countones(s_tready) <= 1), 64'd1);
    if (!busy) chk("ready_when_idle", 64'(s_tready), 64'd0);
    if (prev_last_hs) chk("idle_after_last", 64'(busy), 64'd0);
    if (prev_stall) begin
      chk("stall_valid_held", 64'(m_tvalid), 64'd1);
      chk("stall_data_held", 64'(o), 64'(prev_o));
    end
    if (m_tvalid && !m_tready) chk("no_ready_when_stalled", 64'(s_tready), 64'd0);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 64'(o), 64'(e));
      end
    end
    hs = s_tvalid & s_tready;
    prev_last_hs = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        acc_cnt[i]++;
        if (gap_chk && after_last) chk("pkt_gap", 64'(cyc - last_acc_cyc), 64'd2);
        after_last = srcq[i][0].last;
        if (srcq[i][0].last) begin
          last_acc_cyc = cyc;
          prev_last_hs = 1'b1;
        end
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_o     = o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(srcq[i].pop_front());
    if (bp_mode) m_tready = 1'($urandom_range(0, 1));
    drive_srcs();
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) step();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      mq[i].delete();
      acc_cnt[i] = 0;
    end
    exp_q.delete();
    ptr_m        = N - 1;
    prev_last_hs = 1'b0;
    prev_stall   = 1'b0;
    after_last   = 1'b0;
    gap_chk      = 1'b0;
    bp_mode      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    clear_model();
    m_tready = 1'b1;
    src_en   = 4'hF;
    drive_srcs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_payload", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tvalid = '0;
    cyc = 0; last_acc_cyc = 0;

    // Single source after reset: keep F,3,0,8; the empty beat is dropped
    do_reset();
    push_beat(0, $urandom, 4'hF, 1'b0);
    push_beat(0, $urandom, 4'h3, 1'b0);
    push_beat(0, $urandom, 4'h0, 1'b0);
    push_beat(0, $urandom, 4'h8, 1'b1);
    predict(4'hF, 1);
    chk("t1_expected_beats", 64'(exp_q.size()), 64'd3);
    drive_srcs();
    step();
    chk("t1_ready_req_cycle", 64'(smp_ready), 64'd0);
    step();
    chk("t1_ready_next_cycle", 64'(smp_ready), 64'b0001);
    chk("t1_busy", 64'(smp_busy), 64'd1);
    chk("t1_no_out_yet", 64'(smp_mvalid), 64'd0);
    step();
    chk("t1_first_out", 64'(smp_mvalid), 64'd1);
    run_until_empty(40);

    // Round robin: sources 0,1,3 each with two back-to-back 2-beat packets
    do_reset();
    gap_chk = 1'b1;
    for (int r = 0; r < 2; r++) begin
      push_rand_pkt(0, 2, 1'b1);
      push_rand_pkt(1, 2, 1'b1);
      push_rand_pkt(3, 2, 1'b1);
    end
    predict(4'hF, 6);
    drive_srcs();
    run_until_empty(100);
    gap_chk = 1'b0;

    // Backpressure: 16-beat packet from source 2 with random m_tready
    do_reset();
    bp_mode = 1'b1;
    push_rand_pkt(2, 16, 1'b0);
    predict(4'hF, 1);
    drive_srcs();
    run_until_empty(400);
    bp_mode  = 1'b0;
    m_tready = 1'b1;
    chk("bp_all_accepted", 64'(acc_cnt[2]), 64'd16);

    // Last-only empty beat on source 1 is still forwarded
    do_reset();
    push_beat(1, $urandom, 4'h0, 1'b1);
    predict(4'hF, 1);
    drive_srcs();
    run_until_empty(40);

    // Mask: source 2 disabled; source 0 disabled mid-packet
    do_reset();
    src_en = 4'b1011;
    push_rand_pkt(2, 2, 1'b0);
    push_rand_pkt(0, 4, 1'b0);
    push_rand_pkt(0, 2, 1'b0);
    predict(4'b1011, 1);
    drive_srcs();
    n = 0;
    while (acc_cnt[0] < 1 && n < 20) begin step(); n++; end
    chk("mask_src0_started", 64'(acc_cnt[0] >= 1), 64'd1);
    src_en = 4'b1010;
    run_until_empty(60);
    repeat (10) step();
    chk("mask_src2_never_granted", 64'(srcq[2].size()), 64'd2);
    chk("mask_src0_not_regranted", 64'(srcq[0].size()), 64'd2);
    chk("mask_idle", 64'(busy), 64'd0);

    // Reset mid-packet after beat 2 of 5, then source 0 has first priority
    do_reset();
    push_rand_pkt(0, 5, 1'b0);
    predict(4'hF, 1);
    drive_srcs();
    n = 0;
    while (acc_cnt[0] < 2 && n < 20) begin step(); n++; end
    chk("rstmid_two_beats", 64'(acc_cnt[0]), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_s_tready", 64'(s_tready), 64'd0);
    clear_model();
    drive_srcs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_rand_pkt(3, 2, 1'b0);
    push_rand_pkt(0, 2, 1'b0);
    predict(4'hF, 2);
    chk("rstmid_model_src0_first", 64'(exp_q[0].user), 64'd0);
    drive_srcs();
    run_until_empty(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
